key_ctrl: RTL

- Bus-mapped controller for the 8 board push-buttons; sits between the raw active-low key pins and the CPU bridge.
- Synchronises and debounces each key; keeps a debounced pressed-state word and a sticky press-event word.
- Raises a maskable interrupt request to the CPU, so software can poll or take interrupts instead of reading bouncing raw pins.

---
 rtl/key_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/key_ctrl.sv
// key_ctrl: synchronises and debounces eight active-low push-buttons, latches sticky press
// events and raises a maskable level interrupt; state, events and mask sit on a small word bus.
module key_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  KeyIn,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    localparam logic [CNT_W-1:0] CntLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]       AddrState = 2'd0;
    localparam logic [1:0]       AddrEvent = 2'd1;
    localparam logic [1:0]       AddrMask  = 2'd2;

    logic [7:0]            sync1_q, sync2_q;
    logic [7:0]            stable_q, stable_d;
    logic [7:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]            event_q, event_d;
    logic [7:0]            mask_q, mask_d;
    logic                  irq_q, irq_d;
    logic [7:0]            press;
    logic [7:0]            clr;
    logic                  unused_din;

    assign unused_din = ^Din[31:8];

    // Per-key debounce: count consecutive cycles away from the stable level.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 8; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        press   = stable_d & ~stable_q;
        clr     = (WE && (Addr == AddrEvent)) ? Din[7:0] : 8'h00;
        // A new press on the same edge as a clear keeps the event set.
        event_d = (event_q & ~clr) | press;
        mask_d  = (WE && (Addr == AddrMask)) ? Din[7:0] : mask_q;
        irq_d   = |(event_q & mask_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            event_q  <= '0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            sync1_q  <= ~KeyIn;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            event_q  <= event_d;
            mask_q   <= mask_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        Dout = 32'h0;
        unique case (Addr)
            AddrState: Dout = {24'h0, stable_q};
            AddrEvent: Dout = {24'h0, event_q};
            AddrMask:  Dout = {24'h0, mask_q};
            default:   Dout = 32'h0;
        endcase
    end

    assign IRQ = irq_q;

endmodule
